// File: rtl/hazard_stall_unit_pkg.sv
// Shared types and constants for the hazard/stall controller.
package hazard_stall_unit_pkg;

  // Default register-address width of the pipeline.
  localparam int unsigned REG_AW_DEFAULT = 4;

  // Scoreboard dest field is sized for the widest supported register file;
  // narrower addresses are zero-extended before storage and comparison.
  localparam int unsigned SB_DEST_W = 8;

  // Register 0 is hard-wired and never creates a dependency.
  localparam logic [SB_DEST_W-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic                 valid;
    logic [SB_DEST_W-1:0] dest;
    logic                 is_load;
  } sb_entry_t;

endpackage

// File: rtl/hazard_sb_match.sv
// Compares one source operand against every scoreboard entry and flags a
// blocking dependency. FORWARD_EN selects load-use-only blocking on entry 0;
// otherwise any valid matching entry blocks (full interlock).
module hazard_sb_match
  import hazard_stall_unit_pkg::*;
#(
  parameter int unsigned REG_AW   = REG_AW_DEFAULT,
  parameter int unsigned SB_DEPTH = 2
) (
  input  logic [REG_AW-1:0]            src_i,
  input  logic                         src_used_i,
  input  sb_entry_t [SB_DEPTH-1:0]     sb_i,
  output logic                         block_o
);

  logic [SB_DEST_W-1:0] src_ext;
  logic                 src_live;

  // Not every entry field participates in every configuration.
  logic unused_sb;
  assign unused_sb = ^sb_i;

  assign src_ext  = SB_DEST_W'(src_i);
  assign src_live = src_used_i && (src_ext != ZERO_REG);

  // Blocking decision for this source.
  always_comb begin
    block_o = 1'b0;
`ifdef FORWARD_EN
    // ALU results are forwarded; only a load one stage ahead must wait.
    block_o = src_live && sb_i[0].valid && sb_i[0].is_load && (sb_i[0].dest == src_ext);
`else
    for (int unsigned k = 0; k < SB_DEPTH; k++) begin
      if (src_live && sb_i[k].valid && (sb_i[k].dest == src_ext)) begin
        block_o = 1'b1;
      end
    end
`endif
  end

endmodule

// File: rtl/hazard_stall_unit.sv
// Hazard detection and stall controller for the in-order pipeline.
// Tracks in-flight destinations in a shifting scoreboard, stalls the ID
// instruction on a blocking dependency, and flushes on a taken branch.
// Optional feature macro: FORWARD_EN (load-use-only blocking).
module hazard_stall_unit
  import hazard_stall_unit_pkg::*;
#(
  parameter int unsigned REG_AW   = REG_AW_DEFAULT,
  parameter int unsigned NUM_SRC  = 2,
  parameter int unsigned SB_DEPTH = 2,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                      clock_i,
  input  logic                      reset_i,
  input  logic                      id_valid_i,
  input  logic [NUM_SRC*REG_AW-1:0] id_src_i,
  input  logic [NUM_SRC-1:0]        id_src_used_i,
  input  logic [REG_AW-1:0]         id_dest_i,
  input  logic                      id_reg_write_i,
  input  logic                      id_is_load_i,
  input  logic                      ex_branch_taken_i,
  output logic                      pc_write_o,
  output logic                      if_id_hold_o,
  output logic                      if_id_flush_o,
  output logic                      id_ex_bubble_o,
  output logic [CNT_W-1:0]          stall_cycles_o
);

  sb_entry_t [SB_DEPTH-1:0] sb_q, sb_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [NUM_SRC-1:0]       src_block;
  logic                     hazard;
  logic                     issue;
  logic [SB_DEST_W-1:0]     dest_ext;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    hazard_sb_match #(
      .REG_AW   (REG_AW),
      .SB_DEPTH (SB_DEPTH)
    ) u_match (
      .src_i      (id_src_i[i*REG_AW +: REG_AW]),
      .src_used_i (id_src_used_i[i]),
      .sb_i       (sb_q),
      .block_o    (src_block[i])
    );
  end

  assign hazard   = id_valid_i && (|src_block);
  assign issue    = id_valid_i && !hazard && !ex_branch_taken_i;
  assign dest_ext = SB_DEST_W'(id_dest_i);

  // Pipeline control: reset, then branch flush, then stall, then run.
  always_comb begin
    pc_write_o     = 1'b1;
    if_id_hold_o   = 1'b0;
    if_id_flush_o  = 1'b0;
    id_ex_bubble_o = 1'b0;
    if (reset_i) begin
      pc_write_o = 1'b1;
    end else if (ex_branch_taken_i) begin
      if_id_flush_o  = 1'b1;
      id_ex_bubble_o = 1'b1;
    end else if (hazard) begin
      pc_write_o     = 1'b0;
      if_id_hold_o   = 1'b1;
      id_ex_bubble_o = 1'b1;
    end
  end

  // Scoreboard shift; entry 0 takes the ID instruction only when it issues.
  always_comb begin
    sb_d = '0;
    if (issue) begin
      sb_d[0].valid   = id_reg_write_i && (dest_ext != ZERO_REG);
      sb_d[0].dest    = dest_ext;
      sb_d[0].is_load = id_is_load_i;
    end
    for (int unsigned k = 1; k < SB_DEPTH; k++) begin
      sb_d[k] = sb_q[k-1];
    end
  end

  // Saturating count of stall cycles that were not overridden by a flush.
  always_comb begin
    cnt_d = cnt_q;
    if (hazard && !ex_branch_taken_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      sb_q  <= '0;
      cnt_q <= '0;
    end else begin
      sb_q  <= sb_d;
      cnt_q <= cnt_d;
    end
  end

  assign stall_cycles_o = cnt_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed self-checking bench for hazard_stall_unit. A second instance with
// a 2-bit counter covers saturation and mid-stall reset.
module tb_hazard_stall_unit;

  localparam logic [3:0] CTL_RUN   = 4'b1000;  // {pc_write, hold, flush, bubble}
  localparam logic [3:0] CTL_STALL = 4'b0101;
  localparam logic [3:0] CTL_FLUSH = 4'b1011;

`ifdef FORWARD_EN
  localparam int ALU_STALLS  = 0;
  localparam int LOAD_STALLS = 1;
  localparam int SAT_PER     = 2;
`else
  localparam int ALU_STALLS  = 2;
  localparam int LOAD_STALLS = 2;
  localparam int SAT_PER     = 3;
`endif

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance (defaults).
  logic        rst;
  logic        id_valid, id_reg_write, id_is_load, br;
  logic [7:0]  id_src;
  logic [1:0]  id_used;
  logic [3:0]  id_dest;
  logic        pc_write, hold, flush, bubble;
  logic [15:0] cnt;
  logic [3:0]  ctl;
  assign ctl = {pc_write, hold, flush, bubble};

  hazard_stall_unit u_dut (
    .clock_i           (clk),
    .reset_i           (rst),
    .id_valid_i        (id_valid),
    .id_src_i          (id_src),
    .id_src_used_i     (id_used),
    .id_dest_i         (id_dest),
    .id_reg_write_i    (id_reg_write),
    .id_is_load_i      (id_is_load),
    .ex_branch_taken_i (br),
    .pc_write_o        (pc_write),
    .if_id_hold_o      (hold),
    .if_id_flush_o     (flush),
    .id_ex_bubble_o    (bubble),
    .stall_cycles_o    (cnt)
  );

  // Small-counter instance.
  logic        s_rst;
  logic        s_pc_write, s_hold, s_flush, s_bubble;
  logic [1:0]  s_cnt;
  logic [3:0]  s_ctl;
  assign s_ctl = {s_pc_write, s_hold, s_flush, s_bubble};

  hazard_stall_unit #(
    .CNT_W (2)
  ) u_sat (
    .clock_i           (clk),
    .reset_i           (s_rst),
    .id_valid_i        (1'b1),
    .id_src_i          (8'h05),
    .id_src_used_i     (2'b01),
    .id_dest_i         (4'd5),
    .id_reg_write_i    (1'b1),
    .id_is_load_i      (1'b1),
    .ex_branch_taken_i (1'b0),
    .pc_write_o        (s_pc_write),
    .if_id_hold_o      (s_hold),
    .if_id_flush_o     (s_flush),
    .id_ex_bubble_o    (s_bubble),
    .stall_cycles_o    (s_cnt)
  );

  int n_cmp = 0;
  int n_err = 0;
  int exp_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [3:0] s0, input logic [3:0] s1,
                        input logic [1:0] used, input logic [3:0] d, input logic wr,
                        input logic ld, input logic b);
    id_valid     = v;
    id_src       = {s1, s0};
    id_used      = used;
    id_dest      = d;
    id_reg_write = wr;
    id_is_load   = ld;
    br           = b;
  endtask

  task automatic idle(input int n);
    set_id(1'b0, 4'd0, 4'd0, 2'b00, 4'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) tick();
  endtask

  // ID already holds the reader: expect n stall cycles then an issue cycle.
  task automatic expect_stalls(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      #1 chk({tag, "_stall"}, 32'(ctl), 32'(CTL_STALL));
      tick();
    end
    #1 chk({tag, "_issue"}, 32'(ctl), 32'(CTL_RUN));
    tick();
  endtask

  initial begin
    int c;
    int s;
    logic st;

    rst   = 1'b1;
    s_rst = 1'b1;
    // A branch during reset must not leak onto the control outputs.
    set_id(1'b0, 4'd0, 4'd0, 2'b00, 4'd0, 1'b0, 1'b0, 1'b1);
    tick();
    tick();
    chk("reset_ctl", 32'(ctl), 32'(CTL_RUN));
    br  = 1'b0;
    rst = 1'b0;
    #1 chk("idle_ctl", 32'(ctl), 32'(CTL_RUN));
    chk("idle_cnt", 32'(cnt), 32'd0);
    // Empty scoreboard: readers of any register issue.
    set_id(1'b1, 4'd3, 4'd5, 2'b11, 4'd0, 1'b0, 1'b0, 1'b0);
    #1 chk("sb_empty", 32'(ctl), 32'(CTL_RUN));
    tick();
    idle(2);

    // ALU producer r3, reader of r3.
    set_id(1'b1, 4'd0, 4'd0, 2'b00, 4'd3, 1'b1, 1'b0, 1'b0);
    #1 chk("alu_prod", 32'(ctl), 32'(CTL_RUN));
    tick();
    set_id(1'b1, 4'd3, 4'd0, 2'b01, 4'd0, 1'b0, 1'b0, 1'b0);
    expect_stalls("alu_use", ALU_STALLS);
    exp_cnt += ALU_STALLS;
    idle(2);
    chk("alu_cnt", 32'(cnt), 32'(exp_cnt));

    // Load r5, reader of r5 on source 1.
    set_id(1'b1, 4'd0, 4'd0, 2'b00, 4'd5, 1'b1, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 4'd1, 4'd5, 2'b11, 4'd0, 1'b0, 1'b0, 1'b0);
    expect_stalls("load_use", LOAD_STALLS);
    exp_cnt += LOAD_STALLS;
    idle(2);
    chk("load_cnt", 32'(cnt), 32'(exp_cnt));

    // Producer of r0 never blocks a reader of r0.
    set_id(1'b1, 4'd0, 4'd0, 2'b00, 4'd0, 1'b1, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 4'd0, 4'd0, 2'b11, 4'd0, 1'b0, 1'b0, 1'b0);
    #1 chk("r0_nostall", 32'(ctl), 32'(CTL_RUN));
    tick();
    idle(2);

    // Load r4 in flight; matching source marked unused.
    set_id(1'b1, 4'd0, 4'd0, 2'b00, 4'd4, 1'b1, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 4'd4, 4'd0, 2'b10, 4'd0, 1'b0, 1'b0, 1'b0);
    #1 chk("unused_src", 32'(ctl), 32'(CTL_RUN));
    tick();
    idle(2);
    chk("nostall_cnt", 32'(cnt), 32'(exp_cnt));

    // Load-use coincident with a taken branch: flush wins.
    set_id(1'b1, 4'd0, 4'd0, 2'b00, 4'd6, 1'b1, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 4'd6, 4'd0, 2'b01, 4'd7, 1'b1, 1'b0, 1'b1);
    #1 chk("br_flush", 32'(ctl), 32'(CTL_FLUSH));
    tick();
    // The flushed r7 writer must not be in entry 0.
    set_id(1'b1, 4'd7, 4'd0, 2'b01, 4'd0, 1'b0, 1'b0, 1'b0);
    #1 chk("br_bubble", 32'(ctl), 32'(CTL_RUN));
    chk("br_cnt", 32'(cnt), 32'(exp_cnt));
    tick();
    idle(2);

    // Two sources matching two entries: one stall, length set by youngest.
    set_id(1'b1, 4'd0, 4'd0, 2'b00, 4'd8, 1'b1, 1'b0, 1'b0);
    tick();
    set_id(1'b1, 4'd0, 4'd0, 2'b00, 4'd9, 1'b1, 1'b0, 1'b0);
    tick();
    set_id(1'b1, 4'd8, 4'd9, 2'b11, 4'd0, 1'b0, 1'b0, 1'b0);
    expect_stalls("multi", ALU_STALLS);
    exp_cnt += ALU_STALLS;
    idle(2);
    chk("multi_cnt", 32'(cnt), 32'(exp_cnt));

    // Saturation: ID permanently holds "load r5 <- [r5]".
    s_rst = 1'b0;
    c = 0;
    s = 0;
    while (!(s >= 5 && (c % SAT_PER) != 0) && c < 40) begin
      st = ((c % SAT_PER) != 0);
      #1 chk("sat_ctl", 32'(s_ctl), st ? 32'(CTL_STALL) : 32'(CTL_RUN));
      chk("sat_cnt", 32'(s_cnt), (s > 3) ? 32'd3 : 32'(s));
      tick();
      if (st) s++;
      c++;
    end
    // Mid-stall reset ends the stall immediately, counter clears at the edge.
    s_rst = 1'b1;
    #1 chk("rst_mid_ctl", 32'(s_ctl), 32'(CTL_RUN));
    chk("rst_mid_cnt", 32'(s_cnt), 32'd3);
    tick();
    chk("rst_cnt", 32'(s_cnt), 32'd0);
    s_rst = 1'b0;
    #1 chk("rst_release", 32'(s_ctl), 32'(CTL_RUN));
    tick();
    #1 chk("restart_ctl", 32'(s_ctl), 32'(CTL_STALL));
    chk("restart_cnt", 32'(s_cnt), 32'd0);
    tick();
    #1 chk("restart_inc", 32'(s_cnt), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_stall_unit.md
# hazard_stall_unit

Parametrised hazard detection and stall controller for the in-order pipeline. It sits beside the IF/ID and ID/EX registers. It keeps its own scoreboard of destination registers for in-flight instructions, compares the decoding instruction's N source operands against it, and drives PC write-enable, IF/ID hold, bubble insertion and branch flushes. A saturating stall counter is provided for performance monitoring.

## Interface
Parameters:
- REG_AW, 4, register address width
- NUM_SRC, 2, source operands per instruction
- SB_DEPTH, 2, tracked downstream stages (entry 0 = ID/EX, entry 1 = EX/MEM, …); minimum 1
- CNT_W, 16, stall counter width

Ports:
- clock  in  1  the block's single clock
- reset  in  1  synchronous, active-high
- id_valid  in  1  instruction present in ID
- id_src  in  NUM_SRC*REG_AW  packed source register addresses; src i at bits [i*REG_AW +: REG_AW]
- id_src_used  in  NUM_SRC  per-source "operand actually read"
- id_dest  in  REG_AW  destination register
- id_reg_write  in  1  ID instruction writes a register
- id_is_load  in  1  ID instruction is a load
- ex_branch_taken  in  1  branch resolved taken in EX this cycle
- pc_write  out  1  PC update enable
- if_id_hold  out  1  freeze IF/ID
- if_id_flush  out  1  clear IF/ID to NOP
- id_ex_bubble  out  1  force ID/EX control to NOP
- stall_cycles  out  CNT_W  saturating count of stall cycles

## Operation
- Scoreboard entry fields: valid, dest, is_load. Register 0 is hard-wired: an instruction with id_dest==0 is never recorded as valid.
- Each cycle, entries shift: entry k+1 ← entry k, and entry SB_DEPTH-1 falls off.
- Entry 0 is loaded from ID (valid = id_valid & id_reg_write & dest≠0) only when ID issues: no stall and no flush. Otherwise entry 0 loads a bubble (valid=0).
- Source i matches entry k when: id_src_used[i], src≠0, entry k valid, and dests are equal.
- hazard = id_valid & (any blocking match), where the blocking set depends on FORWARD_EN (see Configuration).
- Priority, highest first:
  - reset
  - ex_branch_taken: if_id_flush=1, id_ex_bubble=1, pc_write=1, if_id_hold=0. Any hazard is ignored.
  - hazard: pc_write=0, if_id_hold=1, id_ex_bubble=1.
  - Otherwise: pc_write=1, all other control outputs 0.
- stall_cycles increments by 1 on each hazard cycle that is not flushed, and saturates at all-ones.

## Timing
- Control outputs are combinational from current ID inputs and the registered scoreboard. There is no added latency.
- The scoreboard and counter update on the rising clock edge.
- While reset=1, outputs are: pc_write=1, if_id_hold=0, if_id_flush=0, id_ex_bubble=0.
- At the first edge with reset=1: all scoreboard entries are cleared to invalid and stall_cycles=0.
- Reset asserted mid-stall: the stall ends on the same cycle, and no in-flight entry survives.
- Stall length: a blocking entry at position k releases once it shifts past the blocking window. Without forwarding this takes SB_DEPTH-k cycles; with forwarding, a load-use takes exactly 1 cycle.
- A branch and a hazard in the same cycle: the flush wins. The counter does not increment, and entry 0 gets a bubble.
- Several sources matching several entries give one stall signal; the duration is set by the youngest (lowest k) blocking entry.

## Configuration
- FORWARD_EN defined: the blocking set is entry 0 with is_load=1 only. The ALU-to-ALU result is assumed forwarded, giving a 1-cycle load-use stall.
- FORWARD_EN undefined: the blocking set is every valid entry 0..SB_DEPTH-1. This is full interlock and is the default.

## Structure
- A shared package holds:
  - the scoreboard entry struct (valid, dest, is_load)
  - the REG_AW default
  - the ZERO_REG constant
- One sub-module, hazard_sb_match, is natural. It takes one source against all SB_DEPTH entries and returns a blocking flag. It is instantiated NUM_SRC times.

## Test plan
- Reset, then idle: pc_write=1, all other control outputs 0, stall_cycles=0, scoreboard empty.
- FORWARD_EN undefined, SB_DEPTH=2: issue r3 ← …, then an instruction reading r3. Expect 2 stall cycles (pc_write=0, if_id_hold=1, id_ex_bubble=1), then issue; stall_cycles=2.
- FORWARD_EN defined: load r5, then add reading r5. Expect exactly 1 stall cycle. A non-load r5 producer followed by a reader gives 0 stalls.
- Producer writing r0, then a reader of r0: no stall. A source with id_src_used=0 that matches r4 in flight: no stall.
- A load-use hazard coincident with ex_branch_taken=1: if_id_flush=1, id_ex_bubble=1, pc_write=1, stall_cycles unchanged, entry 0 invalid next cycle.
- CNT_W=2: force 5 stall cycles. stall_cycles goes 1, 2, 3, then holds at 3. Asserting reset mid-stall clears the stall the same cycle and the counter to 0 at the edge.
